vtx_mem_txn_recorder: RTL and testbench

- Monitors the coprocessor instruction handshake and memory bus.
- Records up to NTXN memory transactions per instruction, including address, data, byte enables, response data and error.
- Presents them as flattened per-slot arrays with a one-cycle vtx_valid pulse at retirement.
- Feeds the formal checker harness and replaces the fixed four-slot memory transaction ports with a parametrised, protocol-aware capture block.

---
 rtl/vtx_mem_txn_recorder.sv | 185 ++++++++++++++++++
 tb/tb_vtx_mem_txn_recorder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtx_mem_txn_recorder.sv
// Captures one coprocessor instruction and the memory transactions it issues,
// then presents the record with a single-cycle vtx_valid pulse at retirement.
module vtx_mem_txn_recorder #(
    parameter int NTXN = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int CW   = $clog2(NTXN + 1)
) (
    input  logic                   vtx_clk,
    input  logic                   vtx_resetn,
    input  logic                   cop_req,
    input  logic                   cop_acc,
    input  logic [31:0]            cop_instr,
    input  logic                   cop_rsp,
    input  logic                   cop_rsp_acc,
    input  logic [2:0]             cop_result,
    input  logic                   mem_cen,
    input  logic                   mem_stall,
    input  logic                   mem_wen,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_wdata,
    input  logic [DW/8-1:0]        mem_ben,
    input  logic [DW-1:0]          mem_rdata,
    input  logic                   mem_error,
    output logic                   vtx_valid,
    output logic [31:0]            vtx_instr_enc,
    output logic [2:0]             vtx_instr_result,
    output logic [CW-1:0]          vtx_txn_count,
    output logic [NTXN-1:0]        vtx_mem_cen,
    output logic [NTXN-1:0]        vtx_mem_wen,
    output logic [NTXN*AW-1:0]     vtx_mem_addr,
    output logic [NTXN*DW-1:0]     vtx_mem_wdata,
    output logic [NTXN*DW/8-1:0]   vtx_mem_ben,
    output logic [NTXN*DW-1:0]     vtx_mem_rdata,
    output logic [NTXN-1:0]        vtx_mem_error,
    output logic                   vtx_txn_overflow,
    output logic                   vtx_stray_txn
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          issue_s;
    logic          retire_s;
    logic          macc_s;
    logic          start_s;
    logic          store_s;
    logic          ovf_s;
    logic          stray_s;
    logic          latch_result_s;
    logic          resp_pend_r;
    logic [CW-1:0] resp_idx_r;

    assign issue_s  = cop_req & cop_acc;
    assign retire_s = cop_rsp & cop_rsp_acc;
    assign macc_s   = mem_cen & ~mem_stall;

    // Next-state and per-cycle capture controls.
    always_comb begin
        state_next_s   = state_r;
        start_s        = 1'b0;
        store_s        = 1'b0;
        ovf_s          = 1'b0;
        stray_s        = 1'b0;
        latch_result_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stray_s = macc_s;
                if (issue_s) begin
                    start_s      = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (macc_s) begin
                    if (vtx_txn_count < CW'(NTXN)) begin
                        store_s = 1'b1;
                    end else begin
                        ovf_s = 1'b1;
                    end
                end else begin
                    store_s = 1'b0;
                end
                // A request accepted with retire still owes a response next cycle.
                if (retire_s) begin
                    latch_result_s = 1'b1;
                    state_next_s   = macc_s ? ST_DRAIN : ST_REPORT;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DRAIN: begin
                stray_s      = macc_s;
                state_next_s = ST_REPORT;
            end
            ST_REPORT: begin
                stray_s = macc_s;
                if (issue_s) begin
                    start_s      = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, record registers and response capture.
    always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
        if (!vtx_resetn) begin
            state_r          <= ST_IDLE;
            resp_pend_r      <= 1'b0;
            resp_idx_r       <= '0;
            vtx_valid        <= 1'b0;
            vtx_instr_enc    <= 32'd0;
            vtx_instr_result <= 3'd0;
            vtx_txn_count    <= '0;
            vtx_mem_cen      <= '0;
            vtx_mem_wen      <= '0;
            vtx_mem_addr     <= '0;
            vtx_mem_wdata    <= '0;
            vtx_mem_ben      <= '0;
            vtx_mem_rdata    <= '0;
            vtx_mem_error    <= '0;
            vtx_txn_overflow <= 1'b0;
            vtx_stray_txn    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            vtx_valid   <= (state_next_s == ST_REPORT);
            resp_pend_r <= store_s;
            if (stray_s) begin
                vtx_stray_txn <= 1'b1;
            end
            if (latch_result_s) begin
                vtx_instr_result <= cop_result;
            end
            if (ovf_s) begin
                vtx_txn_overflow <= 1'b1;
            end
            if (start_s) begin
                vtx_instr_enc    <= cop_instr;
                vtx_txn_count    <= '0;
                vtx_txn_overflow <= 1'b0;
                vtx_mem_cen      <= '0;
                vtx_mem_wen      <= '0;
                vtx_mem_addr     <= '0;
                vtx_mem_wdata    <= '0;
                vtx_mem_ben      <= '0;
                vtx_mem_rdata    <= '0;
                vtx_mem_error    <= '0;
            end
            if (store_s) begin
                vtx_txn_count <= vtx_txn_count + CW'(1);
                resp_idx_r    <= vtx_txn_count;
            end
            for (int i = 0; i < NTXN; i++) begin
                if (store_s && (vtx_txn_count == CW'(i))) begin
                    vtx_mem_cen[i]              <= 1'b1;
                    vtx_mem_wen[i]              <= mem_wen;
                    vtx_mem_addr[i*AW +: AW]    <= mem_addr;
                    vtx_mem_wdata[i*DW +: DW]   <= mem_wdata;
                    vtx_mem_ben[i*BW +: BW]     <= mem_ben;
                end
                if (resp_pend_r && (resp_idx_r == CW'(i))) begin
                    vtx_mem_rdata[i*DW +: DW] <= mem_rdata;
                    vtx_mem_error[i]          <= mem_error;
                end
            end
        end
    end

endmodule

// File: tb/tb_vtx_mem_txn_recorder.sv
// Directed bench for vtx_mem_txn_recorder: expected records are queued as
// instructions retire and compared when the recorder raises vtx_valid.
module tb_vtx_mem_txn_recorder;

    localparam int NTXN = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 cop_req, cop_acc, cop_rsp, cop_rsp_acc;
    logic [31:0]          cop_instr;
    logic [2:0]           cop_result;
    logic                 mem_cen, mem_stall, mem_wen, mem_error;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, mem_rdata;
    logic [DW/8-1:0]      mem_ben;
    logic                 vtx_valid, vtx_txn_overflow, vtx_stray_txn;
    logic [31:0]          vtx_instr_enc;
    logic [2:0]           vtx_instr_result;
    logic [CW-1:0]        vtx_txn_count;
    logic [NTXN-1:0]      vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [NTXN*AW-1:0]   vtx_mem_addr;
    logic [NTXN*DW-1:0]   vtx_mem_wdata, vtx_mem_rdata;
    logic [NTXN*DW/8-1:0] vtx_mem_ben;

    typedef struct packed {
        logic [31:0]  enc;
        logic [2:0]   res;
        logic [2:0]   cnt;
        logic [3:0]   cen;
        logic [3:0]   wen;
        logic [3:0]   err;
        logic [127:0] addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        logic [15:0]  ben;
        logic         ovf;
    } rec_t;

    rec_t cur;
    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   waited;

    vtx_mem_txn_recorder #(.NTXN(NTXN), .AW(AW), .DW(DW), .CW(CW)) dut (
        .vtx_clk(clk), .vtx_resetn(rst_n),
        .cop_req(cop_req), .cop_acc(cop_acc), .cop_instr(cop_instr),
        .cop_rsp(cop_rsp), .cop_rsp_acc(cop_rsp_acc), .cop_result(cop_result),
        .mem_cen(mem_cen), .mem_stall(mem_stall), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_rdata(mem_rdata), .mem_error(mem_error),
        .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc),
        .vtx_instr_result(vtx_instr_result), .vtx_txn_count(vtx_txn_count),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen),
        .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
        .vtx_mem_ben(vtx_mem_ben), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_error(vtx_mem_error), .vtx_txn_overflow(vtx_txn_overflow),
        .vtx_stray_txn(vtx_stray_txn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] enc);
        cop_req = 1'b1; cop_acc = 1'b1; cop_instr = enc;
        cur = '0;
        cur.enc = enc;
        cyc();
        cop_req = 1'b0; cop_acc = 1'b0;
    endtask

    // One accepted request; its response is driven in the following cycle.
    task automatic acc(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] ben, input logic [31:0] rdata, input logic err,
                       input logic ret, input logic [2:0] res);
        int idx;
        mem_cen = 1'b1; mem_stall = 1'b0; mem_wen = wen;
        mem_addr = addr; mem_wdata = wdata; mem_ben = ben;
        if (ret) begin
            cop_rsp = 1'b1; cop_rsp_acc = 1'b1; cop_result = res;
        end
        if (cur.cnt < 3'd4) begin
            idx = int'(cur.cnt);
            cur.cen[idx] = 1'b1;
            cur.wen[idx] = wen;
            cur.err[idx] = err;
            cur.addr[idx*32 +: 32]  = addr;
            cur.wdata[idx*32 +: 32] = wdata;
            cur.rdata[idx*32 +: 32] = rdata;
            cur.ben[idx*4 +: 4]     = ben;
            cur.cnt = cur.cnt + 3'd1;
        end else begin
            cur.ovf = 1'b1;
        end
        if (ret) begin
            cur.res = res;
            exp_q.push_back(cur);
        end
        cyc();
        mem_cen = 1'b0; mem_wen = 1'b0; cop_rsp = 1'b0; cop_rsp_acc = 1'b0;
        mem_rdata = rdata; mem_error = err;
    endtask

    task automatic stall(input int n);
        mem_cen = 1'b1; mem_stall = 1'b1; mem_wen = 1'b1; mem_addr = 32'hBAD0_0000;
        for (int k = 0; k < n; k++) begin
            cyc();
            mem_rdata = 32'hFFFF_0000 + 32'(k);
        end
        mem_cen = 1'b0; mem_stall = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic retire(input logic [2:0] res);
        cop_rsp = 1'b1; cop_rsp_acc = 1'b1; cop_result = res;
        cur.res = res;
        exp_q.push_back(cur);
        cyc();
        cop_rsp = 1'b0; cop_rsp_acc = 1'b0;
    endtask

    task automatic wait_report(input string tag, output int w);
        rec_t e;
        w = 0;
        while (!vtx_valid && w < 10) begin
            cyc();
            w++;
        end
        chk({tag, "_valid"}, 128'(vtx_valid), 128'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_enc"},   128'(vtx_instr_enc),    128'(e.enc));
            chk({tag, "_res"},   128'(vtx_instr_result), 128'(e.res));
            chk({tag, "_count"}, 128'(vtx_txn_count),    128'(e.cnt));
            chk({tag, "_cen"},   128'(vtx_mem_cen),      128'(e.cen));
            chk({tag, "_wen"},   128'(vtx_mem_wen),      128'(e.wen));
            chk({tag, "_addr"},  128'(vtx_mem_addr),     e.addr);
            chk({tag, "_wdata"}, 128'(vtx_mem_wdata),    e.wdata);
            chk({tag, "_ben"},   128'(vtx_mem_ben),      128'(e.ben));
            chk({tag, "_rdata"}, 128'(vtx_mem_rdata),    e.rdata);
            chk({tag, "_err"},   128'(vtx_mem_error),    128'(e.err));
            chk({tag, "_ovf"},   128'(vtx_txn_overflow), 128'(e.ovf));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cop_req = 1'b0; cop_acc = 1'b0; cop_instr = 32'd0;
        cop_rsp = 1'b0; cop_rsp_acc = 1'b0; cop_result = 3'd0;
        mem_cen = 1'b0; mem_stall = 1'b0; mem_wen = 1'b0; mem_error = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_ben = 4'd0; mem_rdata = 32'd0;
        cur = '0;
        cyc();
        cyc();
        chk("rst_valid", 128'(vtx_valid), 128'd0);
        chk("rst_count", 128'(vtx_txn_count), 128'd0);
        chk("rst_cen",   128'(vtx_mem_cen), 128'd0);
        chk("rst_stray", 128'(vtx_stray_txn), 128'd0);
        rst_n = 1'b1;
        cyc();

        // Single load
        issue(32'h0000_202B);
        acc(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd0);
        retire(3'd0);
        wait_report("load", waited);
        chk("load_latency", 128'(waited), 128'd0);
        cyc();
        chk("load_pulse", 128'(vtx_valid), 128'd0);
        chk("load_hold", 128'(vtx_txn_count), 128'd1);

        // Four stores with a stall
        issue(32'h0000_1111);
        acc(1'b1, 32'h200, 32'hA0, 4'h1, 32'h1, 1'b0, 1'b0, 3'd0);
        stall(3);
        acc(1'b1, 32'h204, 32'hA1, 4'h3, 32'h2, 1'b1, 1'b0, 3'd0);
        acc(1'b1, 32'h208, 32'hA2, 4'hC, 32'h3, 1'b0, 1'b0, 3'd0);
        acc(1'b1, 32'h20C, 32'hA3, 4'hF, 32'h4, 1'b0, 1'b0, 3'd0);
        retire(3'd2);
        wait_report("stores", waited);

        // Overflow
        issue(32'h0000_3333);
        for (int k = 0; k < 6; k++) begin
            acc(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF, 32'h7000 + 32'(k), 1'b0, 1'b0, 3'd0);
        end
        retire(3'd1);
        wait_report("ovf", waited);

        // Retire alongside the last request: DRAIN then REPORT
        issue(32'h0000_4444);
        acc(1'b0, 32'h40, 32'h0, 4'hF, 32'h11, 1'b0, 1'b0, 3'd0);
        acc(1'b0, 32'h44, 32'h0, 4'hF, 32'h55, 1'b0, 1'b1, 3'd5);
        chk("drain_novalid", 128'(vtx_valid), 128'd0);
        wait_report("drain", waited);
        chk("drain_latency", 128'(waited), 128'd1);

        // Back-to-back: minimum latency, then issue inside REPORT
        issue(32'h0000_5555);
        retire(3'd3);
        wait_report("b2b", waited);
        chk("b2b_latency", 128'(waited), 128'd0);
        issue(32'hCAFE_0001);
        chk("b2b_pulse", 128'(vtx_valid), 128'd0);
        chk("b2b_count", 128'(vtx_txn_count), 128'd0);
        chk("b2b_cen",   128'(vtx_mem_cen), 128'd0);
        chk("b2b_enc",   128'(vtx_instr_enc), 128'h0000_0000_0000_0000_0000_0000_CAFE_0001);
        acc(1'b1, 32'h500, 32'h99, 4'h2, 32'h66, 1'b1, 1'b0, 3'd0);
        retire(3'd4);
        wait_report("b2b2", waited);

        // Asynchronous reset mid-instruction
        issue(32'h0000_6666);
        acc(1'b0, 32'h600, 32'h0, 4'hF, 32'h1, 1'b0, 1'b0, 3'd0);
        acc(1'b0, 32'h604, 32'h0, 4'hF, 32'h2, 1'b0, 1'b0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 128'(vtx_txn_count), 128'd0);
        chk("arst_cen",   128'(vtx_mem_cen), 128'd0);
        chk("arst_addr",  128'(vtx_mem_addr), 128'd0);
        chk("arst_enc",   128'(vtx_instr_enc), 128'd0);
        chk("arst_valid", 128'(vtx_valid), 128'd0);
        cyc();
        rst_n = 1'b1;
        cop_rsp = 1'b1; cop_rsp_acc = 1'b1; cop_result = 3'd7;
        cyc();
        cop_rsp = 1'b0; cop_rsp_acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("arst_novalid", 128'(vtx_valid), 128'd0);
            cyc();
        end
        chk("stray_before", 128'(vtx_stray_txn), 128'd0);
        mem_cen = 1'b1; mem_addr = 32'h700;
        cyc();
        mem_cen = 1'b0;
        chk("stray_set", 128'(vtx_stray_txn), 128'd1);
        chk("stray_nostore", 128'(vtx_txn_count), 128'd0);
        cyc();
        chk("stray_sticky", 128'(vtx_stray_txn), 128'd1);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
